// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared state encoding, zero-register number and control bundle.
// Rev    : 1.0
// ============================================================================
package hazard_pkg;

    localparam int ZR_REG = 31;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic idExBubble;
        logic ifIdFlush;
        logic idExFlush;
        logic exMemFlush;
        logic pipeFreeze;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t c_ctrl_run    = 7'b1100000;
    localparam pipe_ctrl_t c_ctrl_bubble = 7'b0010000;
    localparam pipe_ctrl_t c_ctrl_flush  = 7'b1101110;
    localparam pipe_ctrl_t c_ctrl_freeze = 7'b0000001;

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_control_unit_if
// Brief  : Pipeline <-> hazard unit signal bundle. HAZARD_STATS_EN adds counters.
// Rev    : 1.0
// ============================================================================
interface hazard_control_unit_if #(
    parameter int N  = 5
`ifdef HAZARD_STATS_EN
  , parameter int CW = 32
`endif
);
    logic [N-1:0] idRn;
    logic [N-1:0] idRm;
    logic         idUsesRn;
    logic         idUsesRm;
    logic         exMemRead;
    logic [N-1:0] exRd;
    logic         memReq;
    logic         memReady;
    logic         memBranchTaken;
    logic         pcWrite;
    logic         ifIdWrite;
    logic         idExBubble;
    logic         ifIdFlush;
    logic         idExFlush;
    logic         exMemFlush;
    logic         pipeFreeze;
    logic         memTimeout;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stallCount;
    logic [CW-1:0] freezeCount;
`endif

    modport master (
        output idRn, idRm, idUsesRn, idUsesRm, exMemRead, exRd,
               memReq, memReady, memBranchTaken,
        input  pcWrite, ifIdWrite, idExBubble, ifIdFlush, idExFlush,
               exMemFlush, pipeFreeze, memTimeout
`ifdef HAZARD_STATS_EN
      , input  stallCount, freezeCount
`endif
    );

    modport slave (
        input  idRn, idRm, idUsesRn, idUsesRm, exMemRead, exRd,
               memReq, memReady, memBranchTaken,
        output pcWrite, ifIdWrite, idExBubble, ifIdFlush, idExFlush,
               exMemFlush, pipeFreeze, memTimeout
`ifdef HAZARD_STATS_EN
      , output stallCount, freezeCount
`endif
    );

endinterface
`default_nettype wire

// File: rtl/hazard_control_unit_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module : load_use_detect
// Brief  : Flags an ID instruction reading the destination of a load in EX.
// Rev    : 1.0
// ============================================================================
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int N  = 5,
    parameter int ZR = ZR_REG
) (
    input  wire logic [N-1:0] i_idRn,
    input  wire logic [N-1:0] i_idRm,
    input  wire logic         i_idUsesRn,
    input  wire logic         i_idUsesRm,
    input  wire logic         i_exMemRead,
    input  wire logic [N-1:0] i_exRd,
    output logic              o_hit
);
    localparam logic [N-1:0] c_zr = N'(ZR);

    logic w_rnHit;
    logic w_rmHit;

    assign w_rnHit = i_idUsesRn && (i_idRn == i_exRd);
    assign w_rmHit = i_idUsesRm && (i_idRm == i_exRd);
    assign o_hit   = i_exMemRead && (i_exRd != c_zr) && (w_rnHit || w_rmHit);

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_control_unit
// Brief  : Load-use stall, memory-wait freeze and branch-flush sequencing.
//          Optional macro HAZARD_STATS_EN adds stall/freeze counters.
// Rev    : 1.0
// ============================================================================
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int N       = 5,
    parameter int ZR      = ZR_REG,
    parameter int TIMEOUT = 16
`ifdef HAZARD_STATS_EN
  , parameter int CW      = 32
`endif
) (
    input  wire logic         clk,
    input  wire logic         reset,
    hazard_control_unit_if.slave hz
);
    localparam int                  c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]  c_cnt_max = c_CNT_W'(TIMEOUT);

    hazard_state_t      r_state;
    hazard_state_t      w_stateNext;
    logic               r_pendFlush;
    logic               w_pendFlushNext;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [c_CNT_W-1:0] w_waitCntNext;
    logic [c_CNT_W-1:0] w_waitCntInc;
    logic               r_memTimeout;
    logic               w_freeze;
    logic               w_loadUse;
    pipe_ctrl_t         w_ctrl;
    pipe_ctrl_t         w_out;

    load_use_detect #(.N(N), .ZR(ZR)) u_lud (
        .i_idRn      (hz.idRn),
        .i_idRm      (hz.idRm),
        .i_idUsesRn  (hz.idUsesRn),
        .i_idUsesRm  (hz.idUsesRm),
        .i_exMemRead (hz.exMemRead),
        .i_exRd      (hz.exRd),
        .o_hit       (w_loadUse)
    );

    assign w_freeze     = hz.memReq && !hz.memReady;
    assign w_waitCntInc = (r_waitCnt == c_cnt_max) ? r_waitCnt : r_waitCnt + 1'b1;

    always_comb begin
        w_ctrl          = c_ctrl_run;
        w_stateNext     = r_state;
        w_pendFlushNext = r_pendFlush;
        w_waitCntNext   = '0;
        case (r_state)
            MEM_WAIT: begin
                w_pendFlushNext = r_pendFlush | hz.memBranchTaken;
                if (!hz.memReady) begin
                    w_ctrl        = c_ctrl_freeze;
                    w_waitCntNext = w_waitCntInc;
                end else begin
                    // Freeze lifts this cycle: a pending load-use gets its bubble
                    // now, unless a deferred flush will discard the instruction.
                    w_stateNext = w_pendFlushNext ? FLUSH : RUN;
                    if (!w_pendFlushNext && w_loadUse)
                        w_ctrl = c_ctrl_bubble;
                end
            end
            default: begin
                if (w_freeze) begin
                    w_ctrl          = c_ctrl_freeze;
                    w_pendFlushNext = r_pendFlush | hz.memBranchTaken;
                    w_waitCntNext   = w_waitCntInc;
                    w_stateNext     = MEM_WAIT;
                end else if (r_state == FLUSH || hz.memBranchTaken) begin
                    w_ctrl          = c_ctrl_flush;
                    w_pendFlushNext = 1'b0;
                    w_stateNext     = RUN;
                end else if (w_loadUse) begin
                    w_ctrl = c_ctrl_bubble;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pendFlush  <= 1'b0;
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_pendFlush  <= w_pendFlushNext;
            r_waitCnt    <= w_waitCntNext;
            r_memTimeout <= r_memTimeout | (w_waitCntNext == c_cnt_max);
        end
    end

    assign w_out = reset ? c_ctrl_run : w_ctrl;

    assign hz.pcWrite    = w_out.pcWrite;
    assign hz.ifIdWrite  = w_out.ifIdWrite;
    assign hz.idExBubble = w_out.idExBubble;
    assign hz.ifIdFlush  = w_out.ifIdFlush;
    assign hz.idExFlush  = w_out.idExFlush;
    assign hz.exMemFlush = w_out.exMemFlush;
    assign hz.pipeFreeze = w_out.pipeFreeze;
    assign hz.memTimeout = r_memTimeout && !reset;

`ifdef HAZARD_STATS_EN
    logic [CW-1:0] r_stallCount;
    logic [CW-1:0] r_freezeCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCount  <= '0;
            r_freezeCount <= '0;
        end else begin
            if (w_out.idExBubble)
                r_stallCount <= r_stallCount + 1'b1;
            if (w_out.pipeFreeze)
                r_freezeCount <= r_freezeCount + 1'b1;
        end
    end

    assign hz.stallCount  = r_stallCount;
    assign hz.freezeCount = r_freezeCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_control_unit
// Brief  : Directed scoreboard bench for hazard_control_unit.
// Rev    : 1.0
// ============================================================================
module tb_hazard_control_unit;

    // {pcWrite, ifIdWrite, idExBubble, ifIdFlush, idExFlush, exMemFlush, pipeFreeze, memTimeout}
    localparam logic [7:0] E_RUN   = 8'b1100_0000;
    localparam logic [7:0] E_STALL = 8'b0010_0000;
    localparam logic [7:0] E_FLUSH = 8'b1101_1100;
    localparam logic [7:0] E_FRZ   = 8'b0000_0010;
    localparam logic [7:0] E_TO    = 8'b0000_0001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    string      q_tag[$];
    logic [7:0] q_exp[$];

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
    hazard_control_unit_if #(.N(5), .CW(32)) hz ();
    hazard_control_unit #(.N(5), .ZR(31), .TIMEOUT(16), .CW(32)) dut (
        .clk(clk), .reset(reset), .hz(hz)
    );
`else
    hazard_control_unit_if #(.N(5)) hz ();
    hazard_control_unit #(.N(5), .ZR(31), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .hz(hz)
    );
`endif

    task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                         input logic urm, input logic exmr, input logic [4:0] exrd,
                         input logic mreq, input logic mrdy, input logic br);
        hz.idRn = rn;  hz.idRm = rm;  hz.idUsesRn = urn;  hz.idUsesRm = urm;
        hz.exMemRead = exmr;  hz.exRd = exrd;
        hz.memReq = mreq;  hz.memReady = mrdy;  hz.memBranchTaken = br;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expected vector queued with the stimulus, compared mid-cycle, then one clock.
    task automatic step(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        string      t;
        logic [7:0] e;
        q_tag.push_back(tag);
        q_exp.push_back(exp);
        @(negedge clk);
        obs = {hz.pcWrite, hz.ifIdWrite, hz.idExBubble, hz.ifIdFlush,
               hz.idExFlush, hz.exMemFlush, hz.pipeFreeze, hz.memTimeout};
        t = q_tag.pop_front();
        e = q_exp.pop_front();
        n_checks++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", t, obs, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        hz.memReq = 1'b1;
        step("reset_gating", E_RUN);
`ifdef HAZARD_STATS_EN
        check_val("stall_cnt_reset", hz.stallCount, 32'd0);
        check_val("freeze_cnt_reset", hz.freezeCount, 32'd0);
`endif
        reset = 1'b0;
        idle();
        step("idle", E_RUN);

        // load-use through Rn and Rm, and the zero-register / unused-source cases
        drive(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        step("lu_rn", E_STALL);
        idle();
        step("lu_after", E_RUN);
        drive(5'd4, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step("lu_rm", E_STALL);
        drive(5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
        step("lu_zr", E_RUN);
        drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu_unused", E_RUN);

        // plain four-cycle freeze
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("frz4", E_FRZ);
        hz.memReady = 1'b1;
        step("frz4_ready", E_RUN);
        idle();
        step("frz4_after", E_RUN);

        // branch taken during freeze is deferred to one cycle after memReady
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        step("frz_br_first", E_FRZ);
        hz.memBranchTaken = 1'b0;
        step("frz_br", E_FRZ);
        step("frz_br", E_FRZ);
        hz.memReady = 1'b1;
        step("frz_br_ready", E_RUN);
        idle();
        step("deferred_flush", E_FLUSH);
        step("flush_after", E_RUN);

        // load-use coinciding with a freeze is bubbled once the freeze lifts
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step("frz_lu", E_FRZ);
        step("frz_lu", E_FRZ);
        hz.memReady = 1'b1;
        step("frz_lu_ready", E_STALL);
        idle();
        step("frz_lu_after", E_RUN);

        // branch and load-use together: flush only
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        step("br_lu", E_FLUSH);
        idle();
        step("br_lu_after", E_RUN);

        // timeout: 20-cycle wait, flag visible once 16 wait cycles have elapsed
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++)
            step("timeout_wait", (i >= 17) ? (E_FRZ | E_TO) : E_FRZ);
        hz.memReady = 1'b1;
        step("timeout_ready", E_RUN | E_TO);
        idle();
        step("timeout_sticky", E_RUN | E_TO);
        step("timeout_sticky2", E_RUN | E_TO);

        // reset inside MEM_WAIT with a pending flush
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        step("rst_wait_br", E_FRZ | E_TO);
        hz.memBranchTaken = 1'b0;
        step("rst_wait", E_FRZ | E_TO);
        reset = 1'b1;
        idle();
        step("rst_in_wait", E_RUN);
        reset = 1'b0;
        step("rst_no_flush", E_RUN);
        step("rst_no_flush2", E_RUN);
`ifdef HAZARD_STATS_EN
        check_val("stall_cnt_cleared", hz.stallCount, 32'd0);
        check_val("freeze_cnt_cleared", hz.freezeCount, 32'd0);
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        step("stat_lu", E_STALL);
        idle();
        check_val("stall_cnt_one", hz.stallCount, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard and stall controller for the five-stage LEGv8 core.
- Sits in ID, beside the forwarding unit.
- Detects load-use hazards the forwarding unit cannot cover, freezes the pipeline while data memory is busy, and sequences branch flushes.
- Drives PC and IF/ID write enables, the ID/EX bubble, per-register flushes and a global freeze.

Parameters:
N, 5, register-number width
ZR, 31, zero-register number; never a hazard source
TIMEOUT, 16, max consecutive memory-wait cycles before memTimeout
CW, 32, statistics counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
idRn  in  N  first source register of the instruction in ID
idRm  in  N  second source register of the instruction in ID
idUsesRn  in  1  the ID instruction reads idRn
idUsesRm  in  1  the ID instruction reads idRm
exMemRead  in  1  the instruction in EX is a load
exRd  in  N  destination register of the instruction in EX
memReq  in  1  the MEM stage has an active data-memory access
memReady  in  1  data memory completes the access this cycle
memBranchTaken  in  1  a branch resolved taken in MEM this cycle
pcWrite  out  1  PC update enable
ifIdWrite  out  1  IF/ID write enable
idExBubble  out  1  zero the control fields written into ID/EX
ifIdFlush  out  1  clear IF/ID
idExFlush  out  1  clear ID/EX
exMemFlush  out  1  clear EX/MEM
pipeFreeze  out  1  all pipeline registers hold
memTimeout  out  1  sticky error flag

Behaviour:
- Reset: state=RUN, pendFlush=0, waitCnt=0, memTimeout=0.
- During the reset cycle: pcWrite=1, ifIdWrite=1, all other outputs 0.
- Outputs are combinational from state and inputs. State updates on clk.
- States:
  - RUN: normal operation.
  - MEM_WAIT: pipeline frozen, waiting on data memory.
  - FLUSH: flush cycle, either deferred or direct.
- freezeCond = memReq && !memReady.
- Priority: freeze > flush > load-use stall.
- RUN:
  - If freezeCond: assert pipeFreeze, deassert pcWrite and ifIdWrite. Latch pendFlush |= memBranchTaken. Go to MEM_WAIT.
  - Else if memBranchTaken: assert ifIdFlush, idExFlush and exMemFlush for this cycle only. pcWrite=1. Stay in RUN.
  - Else if load-use: pcWrite=0, ifIdWrite=0, idExBubble=1.
    - Load-use = exMemRead && exRd!=ZR && ((idUsesRn && idRn==exRd) || (idUsesRm && idRm==exRd)).
- MEM_WAIT:
  - pipeFreeze=1; pcWrite=0; ifIdWrite=0; no flush and no bubble asserted.
  - waitCnt increments each cycle, saturating at TIMEOUT.
  - When waitCnt reaches TIMEOUT, memTimeout sets and stays set until reset.
  - On memReady: clear waitCnt. Go to FLUSH if pendFlush, else to RUN.
  - While in MEM_WAIT, load-use is not evaluated.
- FLUSH:
  - Assert all three flushes; pcWrite=1; clear pendFlush. Go to RUN.
  - If freezeCond is also true, freeze wins: stay frozen, keep pendFlush, go to MEM_WAIT.
- Load-use stall lasts exactly one cycle, because the load advances to MEM.
- A load whose hazard coincides with a freeze gets its bubble after the freeze lifts.
- memBranchTaken and load-use in the same cycle: flush only; no bubble.
- idExBubble and idExFlush are never asserted together.
- Reset mid-wait: returns to RUN immediately, with pendFlush and waitCnt cleared.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, add two outputs:
  - stallCount, CW bits: increments on every load-use bubble cycle.
  - freezeCount, CW bits: increments on every pipeFreeze cycle.
- Both counters wrap modulo 2^CW and reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - typedef enum hazard_state_t {RUN, MEM_WAIT, FLUSH}
  - localparam ZR_REG=31
  - Output-bundle struct for the pipeline-register controls.
- One natural sub-module: load_use_detect, the combinational comparator producing the load-use hit.
- FSM, timeout counter and statistics stay in the top module.

Test Plan:
1. exMemRead=1, exRd=3, idRn=3, idUsesRn=1 -> one cycle with pcWrite=0, ifIdWrite=0, idExBubble=1. Next cycle (exMemRead=0) pcWrite=1.
2. exMemRead=1, exRd=31, idRn=31, idUsesRn=1 -> no stall. Same with idUsesRn=0 and idRn=exRd=5 -> no stall.
3. memReq=1, memReady=0 for 4 cycles, then memReady=1 -> pipeFreeze high for 4 cycles, deasserted in the cycle memReady=1, memTimeout=0.
4. memBranchTaken=1 in the first freeze cycle -> no flush during the freeze. All three flushes exactly one cycle after memReady, then RUN.
5. memReq=1, memReady=0 held for 20 cycles with TIMEOUT=16 -> memTimeout rises on cycle 16 and stays high after memReady. Only reset clears it.
6. reset asserted in MEM_WAIT with pendFlush=1 -> next cycle RUN, no flush issued. With HAZARD_STATS_EN, counters read 0.
